// File: rtl/regfile_4_pkg.sv
// rtl/regfile_4_pkg.sv - shared sizes and sweep-state encoding for regfile_4
package regfile_4_pkg;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_e;

  // Address 0 is the hardwired-zero register.
  function automatic logic is_zero_addr(input logic [AW-1:0] a);
    return (a == '0);
  endfunction

endpackage

// File: rtl/regfile_4_clr_fsm.sv
// rtl/regfile_4_clr_fsm.sv - clear-sweep pointer and CLEAR/IDLE state
module regfile_4_clr_fsm
  import regfile_4_pkg::*;
#(
  parameter int DEPTH_P = DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic [AW-1:0] ptr,
  output logic          clear_en,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_P - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // State and pointer register; reset always (re)starts a sweep from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: walk every entry once, then idle; clr_req only counts while idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          ptr_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      default: begin
        ptr_d   = '0;
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign ptr      = ptr_q;
  assign clear_en = (state_q == ST_CLEAR);
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: rtl/regfile_4.sv
// rtl/regfile_4.sv - 2-read/1-write register file with clear sweep and write-first bypass
module regfile_4
  import regfile_4_pkg::*;
#(
  parameter int WIDTH = regfile_4_pkg::WIDTH,
  parameter int DEPTH = regfile_4_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic             clr_req,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic [WIDTH-1:0] rd2_q, rd2_d;
  logic [AW-1:0]    ptr;
  logic             clear_en;
  logic             wr_en;

  regfile_4_clr_fsm #(
    .DEPTH_P (DEPTH)
  ) u_clr_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .ptr      (ptr),
    .clear_en (clear_en),
    .busy     (busy)
  );

  // Writes are dropped during reset, during a sweep, and to address 0.
  assign wr_en = !reset && !clear_en && we3 && !is_zero_addr(wa3);

  function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] a);
    if (wr_en && (wa3 == a)) return wd3;
    if (is_zero_addr(a))     return '0;
    return mem_q[a];
  endfunction

  // Storage: sweep zeroes one entry per cycle; reset alone leaves contents intact.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem_q[ptr] <= '0;
    end else if (wr_en) begin
      mem_q[wa3] <= wd3;
    end
  end

  // Read-data next state: zero while sweeping, otherwise write-first lookup.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (!clear_en) begin
      rd1_d = read_word(ra1);
      rd2_d = read_word(ra2);
    end
  end

  // Registered read ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign rd1 = rd1_q;
  assign rd2 = rd2_q;

endmodule

// File: tb/tb_regfile_4.sv
// tb/tb_regfile_4.sv - self-checking bench for regfile_4
module tb_regfile_4;

  localparam int W = 4;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset, we3, clr_req;
  logic [3:0]   wa3, ra1, ra2;
  logic [W-1:0] wd3;
  logic [W-1:0] rd1, rd2;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents array plus a count of sweep cycles still owed.
  logic [W-1:0] m_mem [D];
  int           sweep_left = 0;
  logic [W-1:0] m_rd1 = '0, m_rd2 = '0;

  regfile_4 dut (
    .clk     (clk),
    .reset   (reset),
    .we3     (we3),
    .wa3     (wa3),
    .wd3     (wd3),
    .ra1     (ra1),
    .ra2     (ra2),
    .clr_req (clr_req),
    .rd1     (rd1),
    .rd2     (rd2),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      sweep_left = D;
      m_rd1 = '0;
      m_rd2 = '0;
    end else if (sweep_left > 0) begin
      m_mem[D - sweep_left] = '0;
      sweep_left--;
      m_rd1 = '0;
      m_rd2 = '0;
    end else begin
      m_rd1 = (we3 && wa3 != 0 && wa3 == ra1) ? wd3 : (ra1 == 0 ? '0 : m_mem[ra1]);
      m_rd2 = (we3 && wa3 != 0 && wa3 == ra2) ? wd3 : (ra2 == 0 ? '0 : m_mem[ra2]);
      if (we3 && wa3 != 0) m_mem[wa3] = wd3;
      if (clr_req) sweep_left = D;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we3 = 0; wa3 = 0; wd3 = 0; ra1 = 0; ra2 = 0; clr_req = 0;
  endtask

  task automatic test_reset();
    int cnt;
    idle_inputs();
    reset = 1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || rd1 !== 0 || rd2 !== 0) begin
      failures++;
      $display("FAIL reset_state busy=%b rd1=%h rd2=%h required busy=1 rd1=0 rd2=0", busy, rd1, rd2);
    end
    reset = 0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      checks++;
      if (rd1 !== 0 || rd2 !== 0) begin
        failures++;
        $display("FAIL reset_sweep_rd rd1=%h rd2=%h required 0", rd1, rd2);
      end
      cnt++;
      tick();
    end
    checks++;
    if (cnt != D) begin
      failures++;
      $display("FAIL reset_busy_len got=%0d required=%0d", cnt, D);
    end
    for (int a = 0; a < D; a++) begin
      ra1 = 4'(a); ra2 = 4'(D - 1 - a);
      tick();
      checks++;
      if (rd1 !== 4'b0000 || rd2 !== 4'b0000) begin
        failures++;
        $display("FAIL reset_readback addr=%0d rd1=%h rd2=%h required 0", a, rd1, rd2);
      end
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    we3 = 1; wa3 = 5; wd3 = 4'b1010;
    tick();
    idle_inputs();
    ra1 = 5; ra2 = 0;
    tick();
    checks++;
    if (rd1 !== 4'b1010 || rd2 !== 4'b0000) begin
      failures++;
      $display("FAIL write_read rd1=%b rd2=%b required 1010 0000", rd1, rd2);
    end
  endtask

  task automatic test_addr0();
    idle_inputs();
    we3 = 1; wa3 = 0; wd3 = 4'b1111; ra1 = 0;
    tick();
    checks++;
    if (rd1 !== 4'b0000) begin
      failures++;
      $display("FAIL addr0_same_cycle rd1=%b required 0000", rd1);
    end
    idle_inputs();
    ra1 = 0;
    tick();
    checks++;
    if (rd1 !== 4'b0000) begin
      failures++;
      $display("FAIL addr0_read rd1=%b required 0000", rd1);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we3 = 1; wa3 = 3; wd3 = 4'b0110; ra1 = 3; ra2 = 3;
    tick();
    checks++;
    if (rd1 !== 4'b0110 || rd2 !== 4'b0110) begin
      failures++;
      $display("FAIL bypass rd1=%b rd2=%b required 0110 0110", rd1, rd2);
    end
    idle_inputs();
  endtask

  task automatic test_clear_sweep();
    int cnt;
    idle_inputs();
    for (int a = 1; a < D; a++) begin
      we3 = 1; wa3 = 4'(a); wd3 = 4'(a);
      tick();
    end
    idle_inputs();
    ra1 = 7;
    tick();
    checks++;
    if (rd1 !== 4'd7) begin
      failures++;
      $display("FAIL fill_check rd1=%h required 7", rd1);
    end
    clr_req = 1;
    tick();
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      we3 = 1; wa3 = 7; wd3 = 4'b1001; ra1 = 7;
      clr_req = (cnt == 3);
      cnt++;
      tick();
      checks++;
      if (rd1 !== 0) begin
        failures++;
        $display("FAIL sweep_rd rd1=%h required 0", rd1);
      end
    end
    checks++;
    if (cnt != D) begin
      failures++;
      $display("FAIL clear_busy_len got=%0d required=%0d", cnt, D);
    end
    idle_inputs();
    ra1 = 7; ra2 = 15;
    tick();
    checks++;
    if (rd1 !== 4'b0000 || rd2 !== 4'b0000) begin
      failures++;
      $display("FAIL clear_readback rd1=%b rd2=%b required 0000 0000", rd1, rd2);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    idle_inputs();
    we3 = 1; wa3 = 12; wd3 = 4'hC;
    tick();
    idle_inputs();
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1;
    tick();
    reset = 0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != D) begin
      failures++;
      $display("FAIL midsweep_busy_len got=%0d required=%0d", cnt, D);
    end
    ra1 = 12;
    tick();
    checks++;
    if (rd1 !== 0) begin
      failures++;
      $display("FAIL midsweep_readback rd1=%h required 0", rd1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 79) == 0);
      clr_req = ($urandom_range(0, 39) == 0);
      we3     = $urandom_range(0, 1);
      wa3     = 4'($urandom);
      wd3     = W'($urandom);
      ra1     = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom);
      ra2     = ($urandom_range(0, 5) == 0) ? ra1 : 4'($urandom);
      tick();
      checks++;
      if (rd1 !== m_rd1 || rd2 !== m_rd2 || busy !== (sweep_left > 0)) begin
        failures++;
        $display("FAIL random cyc=%0d rd1=%h rd2=%h busy=%b required rd1=%h rd2=%h busy=%b",
                 i, rd1, rd2, busy, m_rd1, m_rd2, sweep_left > 0);
      end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    for (int a = 0; a < D; a++) m_mem[a] = '0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_addr0();
    test_bypass();
    test_clear_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_4.md
REGFILE_4 -- requirements
Module: regfile_4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of registers; address width is log2(DEPTH) = 4.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port we3  input  1  write enable.
REQ-006 The block SHALL have port wa3  input  4  write address.
REQ-007 The block SHALL have port wd3  input  WIDTH  write data, driven by the upstream 4-bit 2:1 data-select mux.
REQ-008 The block SHALL have port ra1  input  4  read address, port 1.
REQ-009 The block SHALL have port ra2  input  4  read address, port 2.
REQ-010 The block SHALL have port clr_req  input  1  request a full clear sweep.
REQ-011 The block SHALL have port rd1  output  WIDTH  registered read data, port 1.
REQ-012 The block SHALL have port rd2  output  WIDTH  registered read data, port 2.
REQ-013 The block SHALL have port busy  output  1  high while a clear sweep is in progress.

Function
REQ-014 The block SHALL have two states: CLEAR (sweep in progress) and IDLE (normal operation).
REQ-015 In CLEAR, each cycle SHALL write 0 to reg[ptr] and increment ptr by 1.
REQ-016 In CLEAR, when ptr = DEPTH-1 the block SHALL clear that entry, wrap ptr to 0 and enter IDLE.
REQ-017 A sweep SHALL take exactly DEPTH cycles; busy SHALL be high on exactly those DEPTH cycles.
REQ-018 In IDLE, clr_req = 1 SHALL enter CLEAR with ptr = 0 on the next edge.
REQ-019 In CLEAR, clr_req SHALL be ignored and SHALL NOT restart the sweep.
REQ-020 In IDLE, we3 = 1 with wa3 != 0 SHALL store wd3 in reg[wa3] at the edge.
REQ-021 A write to address 0 SHALL be discarded; reg[0] SHALL always read 0.
REQ-022 In CLEAR, writes SHALL be ignored, and rd1/rd2 SHALL load 0.
REQ-023 Reads SHALL have 1-cycle latency: rdN loads reg[raN] at each edge (IDLE only).
REQ-024 Write-first bypass: if, at an edge in IDLE, we3 = 1, wa3 = raN and wa3 != 0, then rdN SHALL load wd3.
REQ-025 Both read ports SHALL be independent; ra1 = ra2 is legal and SHALL return identical data.
REQ-026 The clr_req edge that starts a sweep SHALL still perform that cycle's IDLE write and reads.

Reset
REQ-027 At an edge with reset = 1, the block SHALL set: state = CLEAR, ptr = 0, rd1 = 0, rd2 = 0, busy = 1.
REQ-028 Register contents SHALL NOT be cleared by reset directly; they SHALL be cleared by the sweep that follows reset.
REQ-029 Reset asserted mid-sweep SHALL restart the sweep from ptr = 0.
REQ-030 After reset deasserts, busy SHALL stay high for DEPTH further cycles, then go low.
REQ-031 Reset SHALL take priority over clr_req and we3.

Structure
REQ-032 The shared package SHALL hold WIDTH, DEPTH, the address width, and the CLEAR/IDLE state encoding.
REQ-033 The sweep pointer and state SHALL be a single sub-module, regfile_4_clr_fsm, exporting ptr, clear_en and busy.
REQ-034 The storage array, write logic and bypass SHALL live in regfile_4.
REQ-035 Implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-036 Reset for 2 cycles, release -> busy = 1 for exactly 16 cycles then 0; all 16 addresses then read 0000.
REQ-037 IDLE, write wa3 = 5, wd3 = 1010; next cycle ra1 = 5 -> rd1 = 1010 one cycle later; ra2 = 0 -> rd2 = 0000.
REQ-038 Write wa3 = 0, wd3 = 1111, then read ra1 = 0 -> rd1 = 0000.
REQ-039 Same cycle: we3 = 1, wa3 = 3, wd3 = 0110, ra1 = ra2 = 3 -> rd1 = rd2 = 0110 after the edge.
REQ-040 Fill reg 1..15 with their own address, pulse clr_req, attempt write wa3 = 7 during busy -> write ignored, busy 16 cycles, reg 7 reads 0000.
REQ-041 Assert reset when ptr = 8 during a sweep -> ptr restarts at 0 and busy stays high 16 cycles after release.
